// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - result-select codes and NOP bundle constants for the W stage
package wb_pkg;

  localparam int WB_ALU     = 0;
  localparam int WB_MEMW    = 1;
  localparam int WB_LINK    = 2;
  localparam int WB_LUI     = 3;
  localparam int WB_HI      = 4;
  localparam int WB_LO      = 5;
  localparam int WB_LB      = 6;
  localparam int WB_LBU     = 7;
  localparam int WB_LH      = 8;
  localparam int WB_LHU     = 9;
  localparam int WB_SEL_MAX = 9;

  // A bubble is an invalid, non-writing ALU-select bundle with all data zero.
  localparam logic NOP_VALID = 1'b0;
  localparam logic NOP_WE    = 1'b0;
  localparam int   NOP_SEL   = WB_ALU;

  typedef enum logic {
    LD_BYTE = 1'b0,
    LD_HALF = 1'b1
  } ld_size_e;

endpackage

// File: rtl/wb_load_ext.sv
// rtl/wb_load_ext.sv - little-endian byte/halfword lane extract with sign or zero extension
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] word,
  input  logic [OFF_W-1:0]  offset,
  input  logic              size,
  input  logic              sign,
  output logic [DATA_W-1:0] ext
);

  logic [OFF_W+2:0] sh_b;
  logic [OFF_W+2:0] sh_h;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic             fill_b;
  logic             fill_h;

  // Halfword lanes ignore offset bit 0, so the half shift drops it.
  assign sh_b   = {offset, 3'b000};
  assign sh_h   = {offset[OFF_W-1:1], 4'b0000};
  assign lane_b = word[sh_b +: 8];
  assign lane_h = word[sh_h +: 16];
  assign fill_b = sign & lane_b[7];
  assign fill_h = sign & lane_h[15];

  always_comb begin
    ext = '0;
    if (size == LD_HALF) begin
      ext = {{(DATA_W-16){fill_h}}, lane_h};
    end else begin
      ext = {{(DATA_W-8){fill_b}}, lane_b};
    end
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - registered MIPS write-back stage and GRF write-data mux
// Optional misaligned-load flag under `WB_ALIGN_CHECK_EN.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int REG_AW = 5,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic              m_valid,
  input  logic [SEL_W-1:0]  m_sel,
  input  logic              m_we,
  input  logic [REG_AW-1:0] m_rd,
  input  logic [DATA_W-1:0] m_alu,
  input  logic [DATA_W-1:0] m_mem,
  input  logic [DATA_W-1:0] m_pc,
  input  logic [IMM_W-1:0]  m_imm,
  input  logic [DATA_W-1:0] m_hi,
  input  logic [DATA_W-1:0] m_lo,
  output logic              w_valid,
  output logic              w_we,
  output logic [REG_AW-1:0] w_rd,
  output logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] w_pc,
  output logic              w_misalign
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  localparam logic [SEL_W-1:0] S_ALU  = SEL_W'(WB_ALU);
  localparam logic [SEL_W-1:0] S_MEMW = SEL_W'(WB_MEMW);
  localparam logic [SEL_W-1:0] S_LINK = SEL_W'(WB_LINK);
  localparam logic [SEL_W-1:0] S_LUI  = SEL_W'(WB_LUI);
  localparam logic [SEL_W-1:0] S_HI   = SEL_W'(WB_HI);
  localparam logic [SEL_W-1:0] S_LO   = SEL_W'(WB_LO);
  localparam logic [SEL_W-1:0] S_LB   = SEL_W'(WB_LB);
  localparam logic [SEL_W-1:0] S_LBU  = SEL_W'(WB_LBU);
  localparam logic [SEL_W-1:0] S_LH   = SEL_W'(WB_LH);
  localparam logic [SEL_W-1:0] S_LHU  = SEL_W'(WB_LHU);
  localparam logic [SEL_W-1:0] S_MAX  = SEL_W'(WB_SEL_MAX);
  localparam logic [SEL_W-1:0] S_NOP  = SEL_W'(NOP_SEL);

  logic              reg_valid;
  logic [SEL_W-1:0]  reg_sel;
  logic              reg_we;
  logic [REG_AW-1:0] reg_rd;
  logic [DATA_W-1:0] reg_alu;
  logic [DATA_W-1:0] reg_mem;
  logic [DATA_W-1:0] reg_pc;
  logic [IMM_W-1:0]  reg_imm;
  logic [DATA_W-1:0] reg_hi;
  logic [DATA_W-1:0] reg_lo;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      reg_valid <= NOP_VALID;
      reg_sel   <= S_NOP;
      reg_we    <= NOP_WE;
      reg_rd    <= '0;
      reg_alu   <= '0;
      reg_mem   <= '0;
      reg_pc    <= '0;
      reg_imm   <= '0;
      reg_hi    <= '0;
      reg_lo    <= '0;
    end else if (en) begin
      reg_valid <= m_valid;
      reg_sel   <= m_sel;
      reg_we    <= m_we;
      reg_rd    <= m_rd;
      reg_alu   <= m_alu;
      reg_mem   <= m_mem;
      reg_pc    <= m_pc;
      reg_imm   <= m_imm;
      reg_hi    <= m_hi;
      reg_lo    <= m_lo;
    end
  end

  logic              legal_sel;
  logic              ld_size;
  logic              ld_sign;
  logic [DATA_W-1:0] ld_val;
  logic [DATA_W-1:0] link_val;
  logic [DATA_W-1:0] lui_val;
  logic              misalign;

  assign legal_sel = (reg_sel <= S_MAX);
  assign ld_size   = (reg_sel == S_LH) || (reg_sel == S_LHU);
  assign ld_sign   = (reg_sel == S_LB) || (reg_sel == S_LH);
  assign link_val  = reg_pc + DATA_W'(8);

  generate
    if (DATA_W > 2 * IMM_W) begin : g_lui_sext
      assign lui_val = {{(DATA_W-2*IMM_W){reg_imm[IMM_W-1]}}, reg_imm, {IMM_W{1'b0}}};
    end else begin : g_lui_exact
      assign lui_val = {reg_imm, {IMM_W{1'b0}}};
    end
  endgenerate

  wb_load_ext #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_ext (
    .word   (reg_mem),
    .offset (reg_alu[OFF_W-1:0]),
    .size   (ld_size),
    .sign   (ld_sign),
    .ext    (ld_val)
  );

`ifdef WB_ALIGN_CHECK_EN
  // Word check looks at off[1:0] only, matching the 32-bit MEMW access size.
  assign misalign = reg_valid &
                    ((ld_size & reg_alu[0]) |
                     ((reg_sel == S_MEMW) & (reg_alu[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    w_data = '0;
    case (reg_sel)
      S_ALU:                   w_data = reg_alu;
      S_MEMW:                  w_data = reg_mem;
      S_LINK:                  w_data = link_val;
      S_LUI:                   w_data = lui_val;
      S_HI:                    w_data = reg_hi;
      S_LO:                    w_data = reg_lo;
      S_LB, S_LBU, S_LH, S_LHU: w_data = ld_val;
      default:                 w_data = '0;
    endcase
  end

  assign w_valid    = reg_valid;
  assign w_rd       = reg_rd;
  assign w_pc       = reg_pc;
  assign w_misalign = misalign;
  assign w_we       = reg_we & reg_valid & (reg_rd != '0) & legal_sel & ~misalign;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset, en, clr;
  logic        m_valid, m_we;
  logic [3:0]  m_sel;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_mem, m_pc, m_hi, m_lo;
  logic [15:0] m_imm;
  logic        w_valid, w_we, w_misalign;
  logic [4:0]  w_rd;
  logic [31:0] w_data, w_pc;

  int passed = 0;
  int total  = 0;

  wb_stage dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .clr        (clr),
    .m_valid    (m_valid),
    .m_sel      (m_sel),
    .m_we       (m_we),
    .m_rd       (m_rd),
    .m_alu      (m_alu),
    .m_mem      (m_mem),
    .m_pc       (m_pc),
    .m_imm      (m_imm),
    .m_hi       (m_hi),
    .m_lo       (m_lo),
    .w_valid    (w_valid),
    .w_we       (w_we),
    .w_rd       (w_rd),
    .w_data     (w_data),
    .w_pc       (w_pc),
    .w_misalign (w_misalign)
  );

  always #5 clk = ~clk;

  task automatic set_bundle(input logic v, input logic [3:0] s, input logic we,
                            input logic [4:0] rd, input logic [31:0] alu,
                            input logic [31:0] mem, input logic [31:0] pc,
                            input logic [15:0] imm, input logic [31:0] hi,
                            input logic [31:0] lo);
    m_valid = v;   m_sel = s;   m_we = we;   m_rd = rd;
    m_alu   = alu; m_mem = mem; m_pc = pc;   m_imm = imm;
    m_hi    = hi;  m_lo  = lo;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; clr = 1'b0;
    set_bundle(1'b1, 4'd0, 1'b1, 5'd3, 32'h1111_2222, 0, 0, 0, 0, 0);
    step();
    total++; if (w_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", w_valid); else passed++;
    total++; if (w_we !== 1'b0) $display("FAIL reset_we got=%b exp=0", w_we); else passed++;
    total++; if (w_data !== 32'h0) $display("FAIL reset_data got=%h exp=00000000", w_data); else passed++;
    total++; if (w_rd !== 5'd0) $display("FAIL reset_rd got=%0d exp=0", w_rd); else passed++;
    reset = 1'b0;
    set_bundle(1'b1, 4'd0, 1'b1, 5'd3, 32'h1234_5678, 0, 0, 0, 0, 0);
    step();
    total++; if (w_data !== 32'h1234_5678) $display("FAIL alu_data got=%h exp=12345678", w_data); else passed++;
    total++; if (w_we !== 1'b1) $display("FAIL alu_we got=%b exp=1", w_we); else passed++;
    total++; if (w_rd !== 5'd3) $display("FAIL alu_rd got=%0d exp=3", w_rd); else passed++;
    total++; if (w_valid !== 1'b1) $display("FAIL alu_valid got=%b exp=1", w_valid); else passed++;
  endtask

  task automatic test_loads();
    logic [3:0]  sel_t [8] = '{4'd6, 4'd6, 4'd6, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1};
    logic [31:0] off_t [8] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd3, 32'd2, 32'd0, 32'd0};
    logic [31:0] exp_t [8] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80,
                               32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 8; i++) begin
      set_bundle(1'b1, sel_t[i], 1'b1, 5'd7, off_t[i], 32'h80FF_7F01, 0, 0, 0, 0);
      step();
      total++;
      if (w_data !== exp_t[i])
        $display("FAIL load_%0d_data sel=%0d off=%0d got=%h exp=%h", i, sel_t[i], off_t[i], w_data, exp_t[i]);
      else passed++;
      total++;
      if (w_we !== 1'b1) $display("FAIL load_%0d_we got=%b exp=1", i, w_we); else passed++;
    end
  endtask

  task automatic test_misc_sources();
    set_bundle(1'b1, 4'd2, 1'b1, 5'd31, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
    step();
    total++; if (w_data !== 32'h0000_0004) $display("FAIL link_data got=%h exp=00000004", w_data); else passed++;
    total++; if (w_pc !== 32'hFFFF_FFFC) $display("FAIL link_pc got=%h exp=fffffffc", w_pc); else passed++;
    set_bundle(1'b1, 4'd3, 1'b1, 5'd8, 0, 0, 0, 16'hBEEF, 0, 0);
    step();
    total++; if (w_data !== 32'hBEEF_0000) $display("FAIL lui_data got=%h exp=beef0000", w_data); else passed++;
    set_bundle(1'b1, 4'd4, 1'b1, 5'd9, 0, 0, 0, 0, 32'hA5A5_A5A5, 32'h5A5A_1234);
    step();
    total++; if (w_data !== 32'hA5A5_A5A5) $display("FAIL hi_data got=%h exp=a5a5a5a5", w_data); else passed++;
    set_bundle(1'b1, 4'd5, 1'b1, 5'd9, 0, 0, 0, 0, 32'hA5A5_A5A5, 32'h5A5A_1234);
    step();
    total++; if (w_data !== 32'h5A5A_1234) $display("FAIL lo_data got=%h exp=5a5a1234", w_data); else passed++;
  endtask

  task automatic test_hold();
    set_bundle(1'b1, 4'd0, 1'b1, 5'd9, 32'hCAFE_F00D, 0, 32'h0000_0040, 0, 0, 0);
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_bundle(1'b1, 4'd4, 1'b1, 5'd2, 32'hDEAD_0000 + i, 0, 32'h100, 0, 32'h1357_9BDF, 0);
      step();
      total++;
      if (w_data !== 32'hCAFE_F00D || w_rd !== 5'd9 || w_we !== 1'b1 || w_pc !== 32'h40)
        $display("FAIL hold_%0d got data=%h rd=%0d we=%b pc=%h exp data=cafef00d rd=9 we=1 pc=00000040",
                 i, w_data, w_rd, w_we, w_pc);
      else passed++;
    end
    en = 1'b1;
  endtask

  task automatic test_bubble();
    clr = 1'b1;
    set_bundle(1'b1, 4'd0, 1'b1, 5'd4, 32'h0BAD_BEEF, 0, 0, 0, 0, 0);
    step();
    clr = 1'b0;
    total++; if (w_valid !== 1'b0) $display("FAIL clr_valid got=%b exp=0", w_valid); else passed++;
    total++; if (w_we !== 1'b0) $display("FAIL clr_we got=%b exp=0", w_we); else passed++;
    total++; if (w_data !== 32'h0) $display("FAIL clr_data got=%h exp=00000000", w_data); else passed++;
    set_bundle(1'b1, 4'd0, 1'b1, 5'd0, 32'h0000_00AA, 0, 0, 0, 0, 0);
    step();
    total++; if (w_we !== 1'b0) $display("FAIL rd0_we got=%b exp=0", w_we); else passed++;
    total++; if (w_data !== 32'h0000_00AA) $display("FAIL rd0_data got=%h exp=000000aa", w_data); else passed++;
    set_bundle(1'b0, 4'd0, 1'b1, 5'd4, 32'h0000_0055, 0, 0, 0, 0, 0);
    step();
    total++; if (w_we !== 1'b0) $display("FAIL invalid_we got=%b exp=0", w_we); else passed++;
    total++; if (w_data !== 32'h0000_0055) $display("FAIL invalid_data got=%h exp=00000055", w_data); else passed++;
  endtask

  task automatic test_illegal();
    logic [3:0] bad_t [3] = '{4'd12, 4'd10, 4'd15};
    for (int i = 0; i < 3; i++) begin
      set_bundle(1'b1, bad_t[i], 1'b1, 5'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h10, 16'hFFFF, 32'h1, 32'h2);
      step();
      total++; if (w_we !== 1'b0) $display("FAIL illegal_%0d_we got=%b exp=0", bad_t[i], w_we); else passed++;
      total++; if (w_data !== 32'h0) $display("FAIL illegal_%0d_data got=%h exp=00000000", bad_t[i], w_data); else passed++;
    end
  endtask

  task automatic test_align();
    set_bundle(1'b1, 4'd8, 1'b1, 5'd6, 32'h0000_0001, 32'h80FF_7F01, 0, 0, 0, 0);
    step();
    total++; if (w_data !== 32'h0000_7F01) $display("FAIL lh_odd_data got=%h exp=00007f01", w_data); else passed++;
`ifdef WB_ALIGN_CHECK_EN
    total++; if (w_misalign !== 1'b1) $display("FAIL lh_odd_misalign got=%b exp=1", w_misalign); else passed++;
    total++; if (w_we !== 1'b0) $display("FAIL lh_odd_we got=%b exp=0", w_we); else passed++;
`else
    total++; if (w_misalign !== 1'b0) $display("FAIL lh_odd_misalign got=%b exp=0", w_misalign); else passed++;
    total++; if (w_we !== 1'b1) $display("FAIL lh_odd_we got=%b exp=1", w_we); else passed++;
`endif
    set_bundle(1'b1, 4'd1, 1'b1, 5'd6, 32'h0000_0002, 32'h80FF_7F01, 0, 0, 0, 0);
    step();
    total++; if (w_data !== 32'h80FF_7F01) $display("FAIL memw_off2_data got=%h exp=80ff7f01", w_data); else passed++;
`ifdef WB_ALIGN_CHECK_EN
    total++; if (w_misalign !== 1'b1 || w_we !== 1'b0) $display("FAIL memw_off2 got misalign=%b we=%b exp 1/0", w_misalign, w_we); else passed++;
`else
    total++; if (w_misalign !== 1'b0 || w_we !== 1'b1) $display("FAIL memw_off2 got misalign=%b we=%b exp 0/1", w_misalign, w_we); else passed++;
`endif
    set_bundle(1'b1, 4'd6, 1'b1, 5'd6, 32'h0000_0001, 32'h80FF_7F01, 0, 0, 0, 0);
    step();
    total++; if (w_misalign !== 1'b0 || w_we !== 1'b1) $display("FAIL lb_odd got misalign=%b we=%b exp 0/1", w_misalign, w_we); else passed++;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0;
    set_bundle(1'b0, 4'd0, 1'b0, 5'd0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_loads();
    test_misc_sources();
    test_hold();
    test_bubble();
    test_illegal();
    test_align();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
